// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution MAC controller.
package conv_pkg;

   localparam int KSIZE  = 9;
   localparam int DATA_W = 4;
   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = 12;
   localparam int IDX_W  = (KSIZE > 1) ? $clog2(KSIZE) : 1;

   // Largest value a pixel-range (product-width) result can take.
   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << PROD_W) - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_e;

endpackage

// File: rtl/conv_weight_rf.sv
// Filter weight store: async clear, synchronous write, combinational read.
module conv_weight_rf
   import conv_pkg::*;
#(
   parameter int NUM = KSIZE,
   parameter int W   = DATA_W,
   parameter int AW  = IDX_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [NUM];
   logic         waddrOk;
   logic         raddrOk;

   // Extra top bit keeps the range check correct when NUM is a power of two.
   assign waddrOk = ({1'b0, waddr_i} < (AW+1)'(NUM));
   assign raddrOk = ({1'b0, raddr_i} < (AW+1)'(NUM));
   assign rdata_o = raddrOk ? mem_q[raddr_i] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && waddrOk) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/conv_mac_ctrl.sv
// Drives an external 4x4 multiplier once per accepted pixel and sums a KSIZE-tap window.
// Define CONV_MAC_SAT_EN to clamp the result to the product range (255).
module conv_mac_ctrl
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              wt_we,
   input  logic [IDX_W-1:0]  wt_addr,
   input  logic [DATA_W-1:0] wt_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [DATA_W-1:0] pix_data,
   output logic              mul_start,
   output logic [DATA_W-1:0] mul_din0,
   output logic [DATA_W-1:0] mul_din1,
   input  logic [PROD_W-1:0] mul_dout,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              busy
);

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   res_data_q;
   logic               res_valid_q;

   logic               accept;
   logic               wtWrite;
   logic [DATA_W-1:0]  weight;
   logic [ACC_W-1:0]   sum_d;
   logic [ACC_W-1:0]   res_d;

   // Weights are only writable between windows so a window sees a fixed filter.
   assign wtWrite = wt_we && (state_q == IDLE);

   conv_weight_rf u_weight_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wtWrite),
      .waddr_i (wt_addr),
      .wdata_i (wt_data),
      .raddr_i (idx_q),
      .rdata_o (weight)
   );

   assign pix_ready = (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign accept    = pix_valid && pix_ready;

   // Operands are forced to zero when idle so the multiplier output is zero too.
   assign mul_start = accept;
   assign mul_din0  = accept ? pix_data : '0;
   assign mul_din1  = accept ? weight   : '0;

   assign sum_d = acc_q + {{(ACC_W-PROD_W){1'b0}}, mul_dout};

`ifdef CONV_MAC_SAT_EN
   assign res_d = (sum_d > SAT_MAX) ? SAT_MAX : sum_d;
`else
   assign res_d = sum_d;
`endif

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  acc_q <= sum_d;
                  idx_q <= idx_q + 1'b1;
                  if (idx_q == IDX_W'(KSIZE - 1)) begin
                     res_data_q  <= res_d;
                     res_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed bench for conv_mac_ctrl with a behavioural 4x4 multiplier.
module tb_conv_mac_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        wt_we;
   logic [3:0]  wt_addr;
   logic [3:0]  wt_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [3:0]  pix_data;
   logic        mul_start;
   logic [3:0]  mul_din0;
   logic [3:0]  mul_din1;
   logic [7:0]  mul_dout;
   logic        res_valid;
   logic        res_ready;
   logic [11:0] res_data;
   logic        busy;

   int nCompared;
   int nMismatch;

   typedef struct {
      logic [35:0] wts;
      logic [35:0] pix;
      bit          gap;
      int          sum;
   } vec_t;

   vec_t vecs [5];

   conv_mac_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .wt_we     (wt_we),
      .wt_addr   (wt_addr),
      .wt_data   (wt_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_data  (pix_data),
      .mul_start (mul_start),
      .mul_din0  (mul_din0),
      .mul_din1  (mul_din1),
      .mul_dout  (mul_dout),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy)
   );

   assign mul_dout = {4'b0, mul_din0} * {4'b0, mul_din1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int satExp(input int s);
`ifdef CONV_MAC_SAT_EN
      return (s > 255) ? 255 : s;
`else
      return s;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic loadWeights(input logic [35:0] wts);
      wt_we = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wt_addr = 4'(i);
         wt_data = wts[i*4 +: 4];
         tick();
      end
      wt_we   = 1'b0;
      wt_addr = 4'h0;
      wt_data = 4'h0;
   endtask

   // Start a window, feed its pixels and leave the controller holding the result.
   task automatic applyStimulus(input logic [35:0] wts, input logic [35:0] pix,
                                input bit gap, input bit wtWeInRun, input int expSum);
      int   k;
      int   cyc;
      int   mulCount;
      logic valid;
      k        = 0;
      cyc      = 0;
      mulCount = 0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      #1;
      checkOutput("run_pix_ready", 32'(pix_ready), 32'd1);
      checkOutput("run_busy", 32'(busy), 32'd1);
      while (k < 9 && cyc < 40) begin
         valid     = gap ? (cyc % 2 == 0) : 1'b1;
         pix_valid = valid;
         pix_data  = valid ? pix[k*4 +: 4] : 4'h0;
         if (wtWeInRun) begin
            wt_we   = 1'b1;
            wt_addr = 4'h0;
            wt_data = 4'h7;
         end
         #1;
         if (mul_start) mulCount++;
         if (valid) begin
            checkOutput("mul_start", 32'(mul_start), 32'd1);
            checkOutput("mul_din0", 32'(mul_din0), 32'(pix[k*4 +: 4]));
            checkOutput("mul_din1", 32'(mul_din1), 32'(wts[k*4 +: 4]));
            checkOutput("early_res_valid", 32'(res_valid), 32'd0);
            k++;
         end else begin
            checkOutput("gap_mul_start", 32'(mul_start), 32'd0);
            checkOutput("gap_mul_din0", 32'(mul_din0), 32'd0);
            checkOutput("gap_mul_din1", 32'(mul_din1), 32'd0);
         end
         cyc++;
         tick();
      end
      pix_valid = 1'b0;
      pix_data  = 4'h0;
      wt_we     = 1'b0;
      wt_data   = 4'h0;
      if (k < 9) checkOutput("window_timeout", 32'(k), 32'd9);
      #1;
      checkOutput("res_valid", 32'(res_valid), 32'd1);
      checkOutput("res_data", 32'(res_data), 32'(satExp(expSum)));
      checkOutput("hold_pix_ready", 32'(pix_ready), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
      checkOutput("mul_start_count", 32'(mulCount), 32'd9);
   endtask

   task automatic releaseResult();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      checkOutput("release_res_valid", 32'(res_valid), 32'd0);
      checkOutput("release_busy", 32'(busy), 32'd0);
      checkOutput("release_pix_ready", 32'(pix_ready), 32'd0);
   endtask

   initial begin
      nCompared = 0;
      nMismatch = 0;
      vecs[0] = '{36'h111111111, 36'h987654321, 1'b0, 45};
      vecs[1] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b0, 2025};
      vecs[2] = '{36'h876543210, 36'h222222222, 1'b1, 72};
      vecs[3] = '{36'h123456789, 36'h987654321, 1'b0, 165};
      vecs[4] = '{36'h000000000, 36'hFFFFFFFFF, 1'b1, 0};

      rst_n     = 1'b0;
      start     = 1'b0;
      wt_we     = 1'b0;
      wt_addr   = 4'h0;
      wt_data   = 4'h0;
      pix_valid = 1'b0;
      pix_data  = 4'h0;
      res_ready = 1'b0;
      tick();
      tick();
      checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
      checkOutput("reset_res_data", 32'(res_data), 32'd0);
      checkOutput("reset_pix_ready", 32'(pix_ready), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_mul_start", 32'(mul_start), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         $display("[TB] vector %0d", v);
         loadWeights(vecs[v].wts);
         applyStimulus(vecs[v].wts, vecs[v].pix, vecs[v].gap, 1'b0, vecs[v].sum);
         releaseResult();
      end

      // Result held under back-pressure; a start during HOLD must not register.
      loadWeights(36'h111111111);
      applyStimulus(36'h111111111, 36'h987654321, 1'b0, 1'b0, 45);
      for (int c = 0; c < 3; c++) begin
         start = (c == 1);
         tick();
         start = 1'b0;
         #1;
         checkOutput("stall_res_valid", 32'(res_valid), 32'd1);
         checkOutput("stall_res_data", 32'(res_data), 32'(satExp(45)));
         checkOutput("stall_pix_ready", 32'(pix_ready), 32'd0);
         checkOutput("stall_busy", 32'(busy), 32'd1);
      end
      releaseResult();
      tick();
      checkOutput("idle_after_hold_busy", 32'(busy), 32'd0);

      // Weight writes during RUN are dropped: weight[0] stays 3.
      loadWeights(36'h000000003);
      applyStimulus(36'h000000003, 36'h111111112, 1'b0, 1'b1, 6);
      releaseResult();

      // Reset after five accepted pixels.
      loadWeights(36'h111111111);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p < 5; p++) begin
         pix_valid = 1'b1;
         pix_data  = 4'hF;
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_pix_ready", 32'(pix_ready), 32'd0);
      checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
      checkOutput("abort_res_data", 32'(res_data), 32'd0);
      checkOutput("abort_mul_start", 32'(mul_start), 32'd0);
      checkOutput("abort_mul_din0", 32'(mul_din0), 32'd0);
      pix_valid = 1'b0;
      pix_data  = 4'h0;
      tick();
      rst_n = 1'b1;
      tick();
      applyStimulus(36'h000000000, 36'h987654321, 1'b0, 1'b0, 0);
      releaseResult();
      loadWeights(36'h222222222);
      applyStimulus(36'h222222222, 36'h987654321, 1'b0, 1'b0, 90);
      releaseResult();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/conv_mac_ctrl.md
Name: conv_mac_ctrl

Overview:
Sequences one shared 4-bit x 4-bit combinational multiplier (Start/din0/din1/dout datapath) to compute a KSIZE-tap convolution: sum over i of pixel[i] * weight[i].
- Holds the filter weights in a local register file.
- Accepts window pixels over a valid/ready stream and drives the multiplier once per accepted pixel.
- Accumulates the products and presents the window result on an output valid/ready handshake.
- Sits between the image-window fetch logic and the result writer in the convolution path.

Parameters:
KSIZE, 9, number of taps per window (3x3 filter)
DATA_W, 4, pixel and weight width; the multiplier operand width
PROD_W, 8, multiplier product width (2*DATA_W)
ACC_W, 12, accumulator/result width; must hold KSIZE*(2^DATA_W-1)^2 (2025 for the defaults)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a window, honoured only in IDLE
wt_we  in  1  weight write strobe, honoured only in IDLE
wt_addr  in  $clog2(KSIZE)  weight index
wt_data  in  DATA_W  weight value
pix_valid  in  1  pixel available
pix_ready  out  1  controller accepts a pixel this cycle
pix_data  in  DATA_W  pixel value, tap order 0..KSIZE-1
mul_start  out  1  multiplier Start
mul_din0  out  DATA_W  multiplier operand 0 (pixel)
mul_din1  out  DATA_W  multiplier operand 1 (weight)
mul_dout  in  PROD_W  multiplier product, same-cycle combinational
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  ACC_W  window sum
busy  out  1  high in RUN or HOLD

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all weights 0, tap index 0, accumulator 0, state IDLE, res_valid 0, res_data 0, pix_ready 0, busy 0.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - wt_we writes wt_data to weight[wt_addr]; addresses >= KSIZE are ignored.
  - start: clear the accumulator and tap index, go to RUN.
  - start and wt_we in the same cycle: the write completes and RUN begins next cycle.
- RUN:
  - pix_ready = 1.
  - On pix_valid & pix_ready:
    - mul_start = 1, mul_din0 = pix_data, mul_din1 = weight[idx].
    - acc <= acc + zero-extended mul_dout; idx <= idx + 1.
  - On the accept where idx = KSIZE-1: res_data <= final sum (acc + mul_dout), res_valid <= 1, go to HOLD.
  - Cycles without a pixel: the multiplier is idle and acc holds.
  - No timeout.
- Multiplier drive: mul_start, mul_din0 and mul_din1 are combinational, and are 0 whenever no pixel is accepted. This guarantees the multiplier output is 0 when unused.
- HOLD:
  - pix_ready = 0.
  - res_valid and res_data are stable until res_ready. On res_valid & res_ready, res_valid <= 0 and the FSM returns to IDLE.
- Ignored inputs:
  - wt_we outside IDLE is dropped; weights never change during a window.
  - start outside IDLE is ignored.
- Latency: result is valid the cycle after the KSIZE-th accepted pixel. Minimum window is KSIZE+2 cycles including start and handshake.
- Arithmetic: unsigned throughout; the accumulator never wraps for legal parameters.
- Reset mid-window: aborts immediately to the reset values. Any partial sum is discarded and weights are cleared.

Optional Feature:
CONV_MAC_SAT_EN
- Defined: res_data = min(sum, 2^PROD_W - 1), i.e. clamped to 255, upper bits zero. Gives pixel-range output for the image writer.
- Undefined: res_data is the full ACC_W sum.

Decomposition:
- Shared package conv_pkg:
  - DATA_W, PROD_W, KSIZE, ACC_W constants.
  - FSM state enum (IDLE/RUN/HOLD).
  - Saturation max constant.
- Sub-module conv_weight_rf:
  - KSIZE x DATA_W register file.
  - Asynchronous clear on rst_n, synchronous write, combinational read by idx.
- The multiplier stays external; this block only drives its ports.

Test Plan:
- Weights all 1 at addr 0..8, start, pixels 1..9 with continuous valid -> res_data = 45 one cycle after the 9th accept; mul_start high for exactly 9 cycles.
- Weights all 15, pixels all 15 -> res_data = 2025 without CONV_MAC_SAT_EN; 255 with it.
- Weights 0..8, pixels all 2, pix_valid toggling every other cycle -> res_data = 72; mul_start and mul_din0/1 = 0 on gap cycles; acc unchanged on gaps.
- res_ready held low 3 cycles after result -> res_valid and res_data stable, pix_ready = 0, busy = 1; a new start in HOLD is ignored; release -> IDLE next cycle.
- wt_we to addr 0 with value 7 during RUN -> weight unchanged; window with weight[0]=3 and pixel 2 contributes 6.
- rst_n low after 5 accepted pixels -> all outputs 0, state IDLE; a subsequent window with reloaded weights computes its correct sum from zero.
